// File: rtl/rcc_pkg.sv
// Shared definitions for the ripple counter capture block.
// Holds the default geometry (counter width, extended count width, filter
// depth) and the encoding of the count / wrap direction bit.
package rcc_pkg;

    localparam int RCC_IN_W_DEF   = 4;
    localparam int RCC_EXT_W_DEF  = 16;
    localparam int RCC_STABLE_DEF = 2;

    // Direction encoding shared by the up input and the wrap_dir output.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/ripple_count_capture_if.sv
// Wrap-event handshake between the capture block and its consumer.
//   wrap_valid : a wrap event is pending (producer -> consumer)
//   wrap_dir   : direction of the pending event, DIR_UP / DIR_DOWN
//   wrap_ready : consumer accepts the pending event (consumer -> producer)
// The event transfers on any rising clock edge where valid and ready are both high.
interface ripple_count_capture_if;

    logic wrap_valid;
    logic wrap_dir;
    logic wrap_ready;

    modport master (
        output wrap_valid,
        output wrap_dir,
        input  wrap_ready
    );

    modport slave (
        input  wrap_valid,
        input  wrap_dir,
        output wrap_ready
    );

endinterface

// File: rtl/rcc_stable_filter.sv
// Synchroniser and settle filter for an asynchronous ripple counter bus.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   cnt_in    : ripple counter value (asynchronous to clk)
//   up        : count direction (quasi-static, asynchronous)
//   cand      : current candidate value (last value seen on the synchronised bus)
//   up_s      : synchronised direction
//   stable    : candidate has been seen for STABLE_CYCLES consecutive samples
//   settle    : the candidate reaches STABLE_CYCLES at the coming edge
//               (the top qualifies this with "differs from the last accepted value")
module rcc_stable_filter
    import rcc_pkg::*;
#(
    parameter int IN_W          = RCC_IN_W_DEF,
    parameter int STABLE_CYCLES = RCC_STABLE_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] cnt_in,
    input  logic            up,
    output logic [IN_W-1:0] cand,
    output logic            up_s,
    output logic            stable,
    output logic            settle
);

    // Run length never exceeds 15, so four bits always suffice.
    localparam int RUN_W = 4;
    localparam logic [RUN_W-1:0] RUN_STABLE = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_PRE    = RUN_W'(STABLE_CYCLES - 1);

    logic [IN_W-1:0]  s1_r;
    logic [IN_W-1:0]  s2_r;
    logic             up1_r;
    logic             up_s_r;
    logic [IN_W-1:0]  cand_r;
    logic [RUN_W-1:0] run_r;
    logic             stable_r;
    logic [IN_W-1:0]  cand_nxt_s;
    logic [RUN_W-1:0] run_nxt_s;

    // Candidate tracking: a new code restarts the run, a repeated code extends it.
    always_comb begin
        cand_nxt_s = cand_r;
        run_nxt_s  = run_r;
        if (s2_r != cand_r) begin
            cand_nxt_s = s2_r;
            run_nxt_s  = 4'd1;
        end else if (run_r < RUN_STABLE) begin
            run_nxt_s  = run_r + 4'd1;
        end else begin
            run_nxt_s  = run_r;
        end
    end

    // Two-flop synchronisers plus candidate/run state; stable is registered
    // from the next run value so it equals (run == STABLE_CYCLES).
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r     <= {IN_W{1'b0}};
            s2_r     <= {IN_W{1'b0}};
            up1_r    <= 1'b0;
            up_s_r   <= 1'b0;
            cand_r   <= {IN_W{1'b0}};
            run_r    <= {RUN_W{1'b0}};
            stable_r <= 1'b0;
        end else begin
            s1_r     <= cnt_in;
            s2_r     <= s1_r;
            up1_r    <= up;
            up_s_r   <= up1_r;
            cand_r   <= cand_nxt_s;
            run_r    <= run_nxt_s;
            stable_r <= (run_nxt_s == RUN_STABLE);
        end
    end

    assign cand   = cand_r;
    assign up_s   = up_s_r;
    assign stable = stable_r;
    assign settle = (s2_r == cand_r) && (run_r == RUN_PRE);

endmodule

// File: rtl/ripple_count_capture.sv
// Capture of a 4-bit ripple up/down counter into a wide extended count.
// The ripple bus is synchronised and filtered (rcc_stable_filter); each newly
// settled value is accumulated as a modulo-2^IN_W delta, and every wrap of
// the small counter is reported on a valid/ready handshake.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   cnt_in     : ripple counter bus (asynchronous)
//   up         : counter direction, 1 = up
//   clear      : synchronous clear of ext_count, wrap event and overrun
//   ext_count  : accumulated progress since reset/clear
//   stable     : current candidate is settled
//   overrun    : sticky, a wrap event was lost while one was pending
//   wrap_if    : wrap_valid / wrap_dir / wrap_ready handshake (master side)
// Build option: define RCC_SAT_EN to make ext_count saturate at all-ones
// (up) and zero (down) instead of wrapping; wrap events are unaffected.
module ripple_count_capture
    import rcc_pkg::*;
#(
    parameter int IN_W          = RCC_IN_W_DEF,
    parameter int EXT_W         = RCC_EXT_W_DEF,
    parameter int STABLE_CYCLES = RCC_STABLE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_W-1:0]       cnt_in,
    input  logic                  up,
    input  logic                  clear,
    output logic [EXT_W-1:0]      ext_count,
    output logic                  stable,
    output logic                  overrun,
    ripple_count_capture_if.master wrap_if
);

    localparam int PAD_W = EXT_W - IN_W;

    logic [IN_W-1:0]  cand_s;
    logic             up_s;
    logic             settle_s;
    logic             accept_s;
    logic             wrap_s;
    logic [IN_W-1:0]  delta_up_s;
    logic [IN_W-1:0]  delta_dn_s;
    logic [EXT_W-1:0] ext_arith_s;

    logic [IN_W-1:0]  last_r;
    logic [EXT_W-1:0] ext_r;
    logic             valid_r;
    logic             dir_r;
    logic             ovr_r;

    logic [IN_W-1:0]  last_nxt_s;
    logic [EXT_W-1:0] ext_nxt_s;
    logic             valid_nxt_s;
    logic             dir_nxt_s;
    logic             ovr_nxt_s;

`ifdef RCC_SAT_EN
    logic [EXT_W:0]   sum_s;
    logic [EXT_W:0]   diff_s;
`else
    logic [EXT_W-1:0] sum_s;
    logic [EXT_W-1:0] diff_s;
`endif

    rcc_stable_filter #(
        .IN_W          (IN_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk    (clk),
        .rst    (rst),
        .cnt_in (cnt_in),
        .up     (up),
        .cand   (cand_s),
        .up_s   (up_s),
        .stable (stable),
        .settle (settle_s)
    );

    // Accept only settled values that differ from the last accepted one.
    assign accept_s   = settle_s && (cand_s != last_r);
    // Both deltas wrap modulo 2^IN_W, so a crossing of 0/max is a small step.
    assign delta_up_s = cand_s - last_r;
    assign delta_dn_s = last_r - cand_s;
    assign wrap_s     = accept_s && ((up_s == DIR_UP) ? (cand_s < last_r) : (cand_s > last_r));

`ifdef RCC_SAT_EN
    // One extra bit exposes carry (up) and borrow (down) for clamping.
    assign sum_s  = {1'b0, ext_r} + {{(PAD_W + 1){1'b0}}, delta_up_s};
    assign diff_s = {1'b0, ext_r} - {{(PAD_W + 1){1'b0}}, delta_dn_s};

    // Saturating accumulate of the accepted delta.
    always_comb begin
        ext_arith_s = ext_r;
        if (up_s == DIR_UP) begin
            if (sum_s[EXT_W]) begin
                ext_arith_s = {EXT_W{1'b1}};
            end else begin
                ext_arith_s = sum_s[EXT_W-1:0];
            end
        end else begin
            if (diff_s[EXT_W]) begin
                ext_arith_s = {EXT_W{1'b0}};
            end else begin
                ext_arith_s = diff_s[EXT_W-1:0];
            end
        end
    end
`else
    assign sum_s  = ext_r + {{PAD_W{1'b0}}, delta_up_s};
    assign diff_s = ext_r - {{PAD_W{1'b0}}, delta_dn_s};

    // Modulo-2^EXT_W accumulate of the accepted delta.
    always_comb begin
        ext_arith_s = ext_r;
        if (up_s == DIR_UP) begin
            ext_arith_s = sum_s;
        end else begin
            ext_arith_s = diff_s;
        end
    end
`endif

    // Next-state for last/ext_count and the wrap handshake; clear wins over accept.
    always_comb begin
        last_nxt_s  = last_r;
        ext_nxt_s   = ext_r;
        valid_nxt_s = valid_r;
        dir_nxt_s   = dir_r;
        ovr_nxt_s   = ovr_r;
        if (clear) begin
            last_nxt_s  = cand_s;
            ext_nxt_s   = {EXT_W{1'b0}};
            valid_nxt_s = 1'b0;
            ovr_nxt_s   = 1'b0;
        end else begin
            if (accept_s) begin
                last_nxt_s = cand_s;
                ext_nxt_s  = ext_arith_s;
            end else begin
                last_nxt_s = last_r;
                ext_nxt_s  = ext_r;
            end
            if (wrap_s) begin
                // A pending event that is being taken this edge frees the slot.
                if (!valid_r || wrap_if.wrap_ready) begin
                    valid_nxt_s = 1'b1;
                    dir_nxt_s   = up_s;
                end else begin
                    ovr_nxt_s   = 1'b1;
                end
            end else if (valid_r && wrap_if.wrap_ready) begin
                valid_nxt_s = 1'b0;
            end else begin
                valid_nxt_s = valid_r;
            end
        end
    end

    // State registers for the accumulated count and wrap reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r  <= {IN_W{1'b0}};
            ext_r   <= {EXT_W{1'b0}};
            valid_r <= 1'b0;
            dir_r   <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            last_r  <= last_nxt_s;
            ext_r   <= ext_nxt_s;
            valid_r <= valid_nxt_s;
            dir_r   <= dir_nxt_s;
            ovr_r   <= ovr_nxt_s;
        end
    end

    assign ext_count          = ext_r;
    assign overrun            = ovr_r;
    assign wrap_if.wrap_valid = valid_r;
    assign wrap_if.wrap_dir   = dir_r;

endmodule

// File: tb/tb_ripple_count_capture.sv
// Self-checking bench for ripple_count_capture. Two instances share the
// stimulus: a default 16-bit one and a 5-bit one (whose ext_count shows the
// wrap vs. saturation behaviour selected by RCC_SAT_EN). Expected outcomes
// are computed by a small behavioural model when each value is driven,
// queued, and compared once the value has had time to settle.
module tb_ripple_count_capture;
    import rcc_pkg::*;

    typedef struct {
        int ext;
        int ext5;
        int valid;
        int dir;
        int ovr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        up;
    logic [3:0]  cnt_in;
    logic [15:0] ext_count;
    logic [4:0]  ext5;
    logic        stable;
    logic        stable5;
    logic        overrun;
    logic        overrun5;

    ripple_count_capture_if wif ();
    ripple_count_capture_if wif5 ();

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    // model state
    int ext_m  = 0;
    int ext5_m = 0;
    int last_m = 0;
    int valid_m = 0;
    int dir_m  = 0;
    int ovr_m  = 0;

    ripple_count_capture dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_in    (cnt_in),
        .up        (up),
        .clear     (clear),
        .ext_count (ext_count),
        .stable    (stable),
        .overrun   (overrun),
        .wrap_if   (wif)
    );

    ripple_count_capture #(.EXT_W(5)) dut5 (
        .clk       (clk),
        .rst       (rst),
        .cnt_in    (cnt_in),
        .up        (up),
        .clear     (clear),
        .ext_count (ext5),
        .stable    (stable5),
        .overrun   (overrun5),
        .wrap_if   (wif5)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int upd(input int e, input int d, input bit u, input int w);
        int mx;
        int n;
        mx = (1 << w) - 1;
        n  = u ? (e + d) : (e - d);
`ifdef RCC_SAT_EN
        if (n > mx) n = mx;
        if (n < 0)  n = 0;
`else
        n = n & mx;
`endif
        return n;
    endfunction

    // Model of one accept edge with value v, direction u, ready level rdy.
    task automatic model_accept(input int v, input bit u, input bit rdy);
        int d;
        bit w;
        if (v == last_m) begin
            if (valid_m != 0 && rdy) valid_m = 0;
        end else begin
            d = u ? ((v - last_m) & 15) : ((last_m - v) & 15);
            w = u ? (v < last_m) : (v > last_m);
            ext_m  = upd(ext_m, d, u, 16);
            ext5_m = upd(ext5_m, d, u, 5);
            last_m = v;
            if (w) begin
                if (valid_m == 0 || rdy) begin
                    valid_m = 1;
                    dir_m   = int'(u);
                end else begin
                    ovr_m = 1;
                end
            end else if (valid_m != 0 && rdy) begin
                valid_m = 0;
            end
        end
    endtask

    task automatic compare_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check_val({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check_val({tag, "_ext"},   32'(ext_count), e.ext);
            check_val({tag, "_ext5"},  32'(ext5), e.ext5);
            check_val({tag, "_valid"}, 32'(wif.wrap_valid), e.valid);
            check_val({tag, "_dir"},   32'(wif.wrap_dir), e.dir);
            check_val({tag, "_ovr"},   32'(overrun), e.ovr);
            check_val({tag, "_stable"}, 32'(stable), 1);
        end
    endtask

    // Drive a new counter value; rdy/clr/rs are applied only on the accept edge
    // (4th edge after the change).
    task automatic step(input string tag, input int v, input bit u,
                        input bit rdy, input bit clr, input bit rs);
        exp_t e;
        int   old;
        old    = ext_m;
        cnt_in = 4'(v);
        up     = u;
        if (rs) begin
            ext_m = 0; ext5_m = 0; last_m = 0; valid_m = 0; dir_m = 0; ovr_m = 0;
            model_accept(v, u, 1'b0);
        end else if (clr) begin
            ext_m = 0; ext5_m = 0; valid_m = 0; ovr_m = 0; last_m = v;
        end else begin
            model_accept(v, u, rdy);
        end
        e.ext = ext_m; e.ext5 = ext5_m; e.valid = valid_m; e.dir = dir_m; e.ovr = ovr_m;
        sb.push_back(e);
        repeat (3) @(posedge clk);
        #1;
        check_val({tag, "_pre"}, 32'(ext_count), old);
        wif.wrap_ready = rdy;
        clear          = clr;
        rst            = rs;
        @(posedge clk);
        #1;
        wif.wrap_ready = 1'b0;
        clear          = 1'b0;
        rst            = 1'b0;
        if (!rs) check_val({tag, "_lat"}, 32'(ext_count), ext_m);
        repeat (rs ? 8 : 4) @(posedge clk);
        #1;
        compare_pop(tag);
    endtask

    // One-clock excursion to v_g then back to the accepted value.
    task automatic glitch(input string tag, input int v_g);
        exp_t e;
        e.ext = ext_m; e.ext5 = ext5_m; e.valid = valid_m; e.dir = dir_m; e.ovr = ovr_m;
        sb.push_back(e);
        cnt_in = 4'(v_g);
        @(posedge clk);
        #1;
        cnt_in = 4'(last_m);
        repeat (2) @(posedge clk);
        #1;
        check_val({tag, "_stable_drop"}, 32'(stable), 0);
        repeat (6) @(posedge clk);
        #1;
        compare_pop(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; up = 1'b1; cnt_in = 4'd0;
        wif.wrap_ready  = 1'b0;
        wif5.wrap_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_ext",    32'(ext_count), 0);
        check_val("rst_valid",  32'(wif.wrap_valid), 0);
        check_val("rst_dir",    32'(wif.wrap_dir), 0);
        check_val("rst_ovr",    32'(overrun), 0);
        check_val("rst_stable", 32'(stable), 0);
        check_val("rst_ext5",   32'(ext5), 0);
        repeat (3) @(posedge clk);
        #1;
        check_val("idle_stable", 32'(stable), 1);

        // up count, glitch rejection
        step("up1", 1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("up2", 2, 1'b1, 1'b0, 1'b0, 1'b0);
        step("up3", 3, 1'b1, 1'b0, 1'b0, 1'b0);
        glitch("glitch", 0);

        // up wrap, held until acknowledged
        step("up14", 14, 1'b1, 1'b0, 1'b0, 1'b0);
        step("up15", 15, 1'b1, 1'b0, 1'b0, 1'b0);
        step("upwrap", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check_val("hold_valid", 32'(wif.wrap_valid), 1);
        wif.wrap_ready = 1'b1;
        @(posedge clk);
        #1;
        wif.wrap_ready = 1'b0;
        valid_m = 0;
        check_val("ack_valid", 32'(wif.wrap_valid), 0);

        // pending up event, then down wrap with ready on the same edge
        step("up1b", 1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("upwrap2", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("simul", 15, 1'b0, 1'b1, 1'b0, 1'b0);

        // wraps while an event is pending and not accepted -> overrun
        step("ovr_up", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("up1c", 1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("dnwrap", 15, 1'b0, 1'b0, 1'b0, 1'b0);

        // clear on an accept edge discards the accept but adopts the candidate
        step("clear", 5, 1'b1, 1'b0, 1'b1, 1'b0);
        step("post_clr", 7, 1'b1, 1'b0, 1'b0, 1'b0);

        // reset mid-filter, then the settled value counts from 0
        step("rst_mid", 9, 1'b1, 1'b0, 1'b0, 1'b1);

        // climb to 30 and past it: 5-bit instance wraps or saturates
        step("c12", 12, 1'b1, 1'b0, 1'b0, 1'b0);
        step("c15", 15, 1'b1, 1'b0, 1'b0, 1'b0);
        step("c2",  2,  1'b1, 1'b0, 1'b0, 1'b0);
        step("c5",  5,  1'b1, 1'b0, 1'b0, 1'b0);
        step("c8",  8,  1'b1, 1'b0, 1'b0, 1'b0);
        step("c11", 11, 1'b1, 1'b0, 1'b0, 1'b0);
        step("c14", 14, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("ext5_at30", 32'(ext5), 30);
        step("c1",  1,  1'b1, 1'b0, 1'b0, 1'b0);
`ifdef RCC_SAT_EN
        check_val("ext5_sat", 32'(ext5), 31);
`else
        check_val("ext5_wrap", 32'(ext5), 1);
`endif
        check_val("ext16_final", 32'(ext_count), 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
